// File: rtl/p_sn_if.sv
// +-----------------------------------------------------------------------+
// | Module   : p_sn_if                                                    |
// | Brief    : Parallel-load / serial-line bundle for the p_sn serialiser |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

interface p_sn_if #(
    parameter int N = 8
);
    logic         enable;
    logic         load_valid;
    logic [N-1:0] load_data;
    logic         load_ready;
    logic         output_1;
    logic         output_en;
    logic         busy;
    logic         done;

    modport master (
        output enable,
        output load_valid,
        output load_data,
        input  load_ready,
        input  output_1,
        input  output_en,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  load_valid,
        input  load_data,
        output load_ready,
        output output_1,
        output output_en,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/p_sn.sv
// +-----------------------------------------------------------------------+
// | Module   : p_sn                                                       |
// | Brief    : Parallel-to-serial frame shifter, MSB first, idle-high.    |
// |            Define P_SN_CRC7_EN to append a CRC7 (x^7+x^3+1) trailer.  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module p_sn #(
    parameter int N = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    p_sn_if.slave     bus
);

    localparam int CW = $clog2(N + 1);

`ifdef P_SN_CRC7_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CRC   = 2'd2,
        STOP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd3
    } state_t;
`endif

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_shift, w_shift_nxt;
    logic [CW-1:0]  r_cnt,   w_cnt_nxt;
    logic           r_out,   w_out_nxt;
    logic           r_oen,   w_oen_nxt;
    logic           r_busy,  w_busy_nxt;
    logic           r_done,  w_done_nxt;
`ifdef P_SN_CRC7_EN
    logic [6:0]     r_crc,     w_crc_nxt;
    logic [2:0]     r_crc_cnt, w_crc_cnt_nxt;
    logic           w_fb;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_out     <= 1'b1;
            r_oen     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef P_SN_CRC7_EN
            r_crc     <= '0;
            r_crc_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out     <= w_out_nxt;
            r_oen     <= w_oen_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef P_SN_CRC7_EN
            r_crc     <= w_crc_nxt;
            r_crc_cnt <= w_crc_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_out_nxt     = r_out;
        w_oen_nxt     = r_oen;
        w_done_nxt    = 1'b0;
`ifdef P_SN_CRC7_EN
        w_crc_nxt     = r_crc;
        w_crc_cnt_nxt = r_crc_cnt;
        w_fb          = r_shift[N-1] ^ r_crc[6];
`endif
        case (r_state)
            IDLE: begin
                // Loading ignores enable so a word can be taken in the done cycle.
                if (bus.load_valid) begin
                    w_shift_nxt = bus.load_data;
                    w_cnt_nxt   = '0;
`ifdef P_SN_CRC7_EN
                    w_crc_nxt   = '0;
`endif
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.enable) begin
                    w_out_nxt   = r_shift[N-1];
                    w_oen_nxt   = 1'b1;
                    w_shift_nxt = {r_shift[N-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + 1'b1;
`ifdef P_SN_CRC7_EN
                    w_crc_nxt   = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
`endif
                    if (r_cnt == CW'(N - 1)) begin
`ifdef P_SN_CRC7_EN
                        w_crc_cnt_nxt = '0;
                        w_state_nxt   = CRC;
`else
                        w_state_nxt   = STOP;
`endif
                    end
                end
            end
`ifdef P_SN_CRC7_EN
            CRC: begin
                if (bus.enable) begin
                    w_out_nxt     = r_crc[6];
                    w_oen_nxt     = 1'b1;
                    w_crc_nxt     = {r_crc[5:0], 1'b0};
                    w_crc_cnt_nxt = r_crc_cnt + 1'b1;
                    if (r_crc_cnt == 3'd6)
                        w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bus.enable) begin
                    w_out_nxt   = 1'b1;
                    w_oen_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.load_ready = (r_state == IDLE);
    assign bus.output_1   = r_out;
    assign bus.output_en  = r_oen;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: doc/p_sn.md
P_SN -- requirements
Module: p_sn

Interface
REQ-001 N, default 8, serial frame data width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 enable  input  1  bit-rate qualifier; shifting advances only on clk edges where enable=1.
REQ-005 load_valid  input  1  parallel word offered.
REQ-006 load_data  input  N  parallel word; bit N-1 is transmitted first.
REQ-007 load_ready  output  1  block can accept a word; equals (state==IDLE), combinational.
REQ-008 output_1  output  1  registered serial line, idle-high.
REQ-009 output_en  output  1  registered; 1 while a frame bit is on output_1 (CMD line drive enable).
REQ-010 busy  output  1  registered; 1 in any state other than IDLE.
REQ-011 done  output  1  registered one-cycle pulse at frame completion.

Function
REQ-012 States SHALL be IDLE, SHIFT, CRC (only when P_SN_CRC7_EN is defined) and STOP.
REQ-013 IDLE: a word is accepted on the edge where load_valid=1 and load_ready=1, regardless of enable; load_data is captured into an N-bit shift register, the bit counter is cleared, and the state becomes SHIFT.
REQ-014 load_valid while load_ready=0 SHALL be ignored; load_data is not sampled.
REQ-015 SHIFT: on each edge with enable=1, output_1 <= shift_reg[N-1], output_en <= 1, shift_reg shifts left one, counter increments.
REQ-016 The first bit is launched on the first enabled edge strictly after the accept edge, never on the accept edge itself.
REQ-017 On the enabled edge launching bit N (counter==N-1), the next state SHALL be CRC if P_SN_CRC7_EN is defined, else STOP.
REQ-018 STOP: on the next enabled edge output_1 <= 1, output_en <= 0, done <= 1, state <= IDLE; each transmitted bit is thus held for exactly one enable period.
REQ-019 done SHALL be 1 for exactly one clk cycle, then 0.
REQ-020 A new word offered in the cycle done=1 SHALL be accepted (back-to-back frames, no idle gap beyond the load cycle).
REQ-021 enable=0 in SHIFT, CRC or STOP SHALL hold all registers and outputs unchanged.
REQ-022 Counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap inside a frame.

Reset
REQ-023 reset=1 at a clk edge SHALL force state IDLE, output_1=1, output_en=0, busy=0, done=0, shift register, counter and CRC register to 0; load_ready=1 after that edge.
REQ-024 reset SHALL take priority over load_valid and enable; a frame interrupted mid-transmission is discarded, no done pulse.

Configuration
REQ-025 Macro P_SN_CRC7_EN defined: a 7-bit CRC (polynomial x^7+x^3+1, init 0) is updated with each launched data bit; the CRC state then launches crc[6] down to crc[0] on 7 further enabled edges with output_en=1, then goes to STOP; frame length N+7 bits.
REQ-026 Macro P_SN_CRC7_EN undefined: no CRC register or CRC state is synthesised; frame length N bits; SHIFT goes directly to STOP.

Verification
REQ-027 N=8, enable=1 constant, load 0xA5 -> output_1 = 1,0,1,0,0,1,0,1 on cycles 2..9 after accept (accept edge = cycle 0), output_en=1 on those cycles, done=1 on cycle 10 only, output_1=1 thereafter.
REQ-028 N=8, enable high 1 cycle in 4, load 0x3C -> each bit held 4 cycles, sequence 0,0,1,1,1,1,0,0, busy=1 throughout, single done pulse.
REQ-029 N=40, P_SN_CRC7_EN defined, load 0x4000000000 (CMD0) -> 40 data bits then CRC bits 1,0,0,1,0,1,0 (0x4A), then done.
REQ-030 N=8, load 0xFF, assert reset after 3 bits launched -> next cycle output_1=1, output_en=0, busy=0, load_ready=1, no done pulse.
REQ-031 N=8, load 0x81, hold load_valid=1 with 0x00 during frame -> 0x00 ignored until done cycle, then accepted; line shows 0x81 then 0x00 back-to-back.
